// File: rtl/quad_enc_pkg.sv
// -----------------------------------------------------------------------------
// quad_enc_pkg
// Shared types and helpers for the quadrature encoder front end.
//   state_e  : decoder FSM states (ST_INIT while filters settle, ST_RUN after)
//   S00..S01 : 2-bit Gray positions, packed as {ch_a, ch_b}
//   next_fwd : forward successor of a Gray position; the reverse successor is
//              the inverse lookup (prev == next_fwd(cur))
// -----------------------------------------------------------------------------
package quad_enc_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;

  // Forward rotation walks 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] next_fwd(input logic [1:0] s);
    logic [1:0] n;
    // NOTE: give every combinational result a default first so no path leaves it unassigned (no latch).
    n = S00;
    case (s)
      S00:     n = S10;
      S10:     n = S11;
      S11:     n = S01;
      S01:     n = S00;
      default: n = S00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_encoder_decoder_if.sv
// -----------------------------------------------------------------------------
// quad_encoder_decoder_if
// Pin bundle between the encoder front end and its environment.
//   ch_a, ch_b : raw encoder channels (asynchronous to clk)
//   enable     : 1 = pulses allowed, 0 = pulses suppressed (tracking continues)
//   err_clr    : synchronous clear of the sticky error
//   up, down   : one-cycle count pulses
//   dir        : 1 = last valid transition forward
//   err        : sticky illegal-transition flag
// master drives the encoder side, slave is the decoder.
// -----------------------------------------------------------------------------
interface quad_encoder_decoder_if;
  logic ch_a;
  logic ch_b;
  logic enable;
  logic err_clr;
  logic up;
  logic down;
  logic dir;
  logic err;

  modport master (
    output ch_a, ch_b, enable, err_clr,
    input  up, down, dir, err
  );

  modport slave (
    input  ch_a, ch_b, enable, err_clr,
    output up, down, dir, err
  );
endinterface

// File: rtl/quad_channel_filter.sv
// -----------------------------------------------------------------------------
// quad_channel_filter
// One encoder channel: 2-flop synchroniser followed by a debounce counter.
// The filtered value follows the synchronised pin only after it has differed
// for FILTER_CYCLES consecutive samples; shorter glitches are dropped.
// Ports:
//   clk, rstn : clock, async active-low reset
//   i_raw     : raw asynchronous pin
//   i_bypass  : 1 = filtered value tracks the synchroniser directly
//   o_filt    : debounced channel value
// -----------------------------------------------------------------------------
module quad_channel_filter #(
  parameter int FILTER_CYCLES = 3,
  parameter int FILTER_W      = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_raw,
  input  logic i_bypass,
  output logic o_filt
);

  localparam logic [FILTER_W-1:0] CNT_LAST = FILTER_W'(FILTER_CYCLES - 1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_filt;
  logic [FILTER_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (i_bypass) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else if (r_sync2 != r_filt) begin
        if (r_cnt == CNT_LAST) begin
          r_filt <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + FILTER_W'(1);
        end
      end else begin
        // Pin agrees with the filtered value again: abandon the pending change.
        r_cnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/quad_encoder_decoder.sv
// -----------------------------------------------------------------------------
// quad_encoder_decoder
// x4 quadrature decoder feeding the up/down counter. Both channels are
// synchronised and debounced, then the filtered Gray position is compared with
// its value one cycle earlier to produce registered up/down pulses, the
// direction flag and a sticky illegal-transition error.
// After reset the FSM sits in ST_INIT, letting the filters load the resting
// encoder position directly so a non-00 rest position causes no pulse or err.
// Ports:
//   clk, rstn : clock, async active-low reset
//   bus       : quad_encoder_decoder_if.slave (pins, controls and outputs)
// -----------------------------------------------------------------------------
module quad_encoder_decoder
  import quad_enc_pkg::*;
#(
  parameter int FILTER_CYCLES = 3,
  parameter int FILTER_W      = 2,
  parameter int INIT_W        = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  quad_encoder_decoder_if.slave   bus
);

  // Covers two synchroniser stages plus one full filter window.
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(2 + FILTER_CYCLES);

  state_e            r_state;
  logic [INIT_W-1:0] r_init_cnt;
  logic [1:0]        r_filt_d;
  logic              r_up;
  logic              r_down;
  logic              r_dir;
  logic              r_err;

  logic              w_filt_a;
  logic              w_filt_b;
  logic [1:0]        w_filt;
  logic              w_bypass;
  logic              w_fwd;
  logic              w_rev;
  logic              w_illegal;

  assign w_bypass = (r_state == ST_INIT);

  quad_channel_filter #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .FILTER_W      (FILTER_W)
  ) u_filt_a (
    .clk      (clk),
    .rstn     (rstn),
    .i_raw    (bus.ch_a),
    .i_bypass (w_bypass),
    .o_filt   (w_filt_a)
  );

  quad_channel_filter #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .FILTER_W      (FILTER_W)
  ) u_filt_b (
    .clk      (clk),
    .rstn     (rstn),
    .i_raw    (bus.ch_b),
    .i_bypass (w_bypass),
    .o_filt   (w_filt_b)
  );

  assign w_filt = {w_filt_a, w_filt_b};

  // A Gray step changes exactly one bit; any other change (both bits) is
  // illegal. next_fwd(x) never equals x, so "no change" is neither fwd nor rev.
  assign w_fwd     = (w_filt == next_fwd(r_filt_d));
  assign w_rev     = (r_filt_d == next_fwd(w_filt));
  assign w_illegal = (w_filt != r_filt_d) && !w_fwd && !w_rev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_filt_d   <= S00;
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_dir      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // Tracking never stops, even with enable low, so no backlog builds up.
      r_filt_d <= w_filt;
      case (r_state)
        ST_INIT: begin
          r_up   <= 1'b0;
          r_down <= 1'b0;
          r_err  <= 1'b0;
          if (r_init_cnt == INIT_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_init_cnt <= r_init_cnt + INIT_W'(1);
          end
        end
        ST_RUN: begin
          r_up   <= w_fwd & bus.enable;
          r_down <= w_rev & bus.enable;
          if (w_fwd) begin
            r_dir <= 1'b1;
          end else if (w_rev) begin
            r_dir <= 1'b0;
          end
          // Set has priority over clear when both land in the same cycle.
          if (w_illegal) begin
            r_err <= 1'b1;
          end else if (bus.err_clr) begin
            r_err <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.up   = r_up;
  assign bus.down = r_down;
  assign bus.dir  = r_dir;
  assign bus.err  = r_err;

endmodule

// File: doc/quad_encoder_decoder.md
Name: quad_encoder_decoder

Overview:
Upstream front end for the 4-bit up/down counter. Takes two raw asynchronous quadrature channels (ch_a, ch_b) from a rotary or linear encoder. Synchronises and debounces both channels, then decodes Gray-code transitions (x4 decoding). Emits one-cycle up/down pulses that drive the counter's Up/Down inputs directly, plus a direction flag and a sticky illegal-transition error.

Parameters:
FILTER_CYCLES, 3, consecutive clk edges a synchronised channel must differ from its filtered value before the filtered value updates (>=1)
FILTER_W, 2, width of the per-channel filter counter; must hold FILTER_CYCLES-1
INIT_W, 3, width of the init counter; must hold 2+FILTER_CYCLES

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  reset, asynchronous, active-low
ch_a  input  1  raw encoder channel A, asynchronous to clk
ch_b  input  1  raw encoder channel B, asynchronous to clk
enable  input  1  1 = pulses allowed; 0 = up/down forced 0, tracking continues
err_clr  input  1  synchronous clear of err
up  output  1  one-cycle pulse per valid forward transition
down  output  1  one-cycle pulse per valid reverse transition
dir  output  1  1 = last valid transition was forward, 0 = reverse
err  output  1  sticky: illegal transition seen

Behaviour:
- Reset (rstn=0, async): sync flops, filt, filt_d, filter counters, up, down, dir and err all 0. FSM goes to INIT.
- Synchroniser: two flops per channel. A pin change is visible at sync2 after 2 clk edges.
- Filter, per channel:
  - If sync2 != filt: when cnt==FILTER_CYCLES-1, then filt<=sync2 and cnt<=0; otherwise cnt<=cnt+1.
  - If sync2 == filt: cnt<=0.
  - Any glitch shorter than FILTER_CYCLES samples is rejected.
- FSM INIT:
  - filt<=sync2 and filt_d<=filt every cycle (filter bypassed).
  - up, down and err are held at 0.
  - Init counter runs 0..2+FILTER_CYCLES; on reaching the terminal count, go to RUN.
  - This prevents spurious pulses or err when the encoder rests at a non-00 position at reset release.
- FSM RUN: filt_d<=filt each cycle. Decode state {filt_a, filt_b} against filt_d:
  - Forward: 00->10, 10->11, 11->01, 01->00. Next edge: up<=enable, dir<=1.
  - Reverse: 00->01, 01->11, 11->10, 10->00. Next edge: down<=enable, dir<=0.
  - No change: up<=0, down<=0.
  - Both bits changed (00<->11, 01<->10): illegal. err<=1, no pulse, dir unchanged.
- up and down are never high together. Each pulse lasts exactly one cycle.
- Latency, pin change to pulse: 3+FILTER_CYCLES clk edges (6 at default).
- enable=0 does not freeze the filters or filt_d. When enable returns to 1, no backlog pulse is produced. dir and err still update while enable=0.
- err_clr=1 clears err on the next edge. If an illegal transition and err_clr occur in the same cycle, the set wins and err stays 1.
- Reset mid-operation aborts any in-flight pulse immediately (async) and re-enters INIT.
- Output pins are registered. No combinational path from any input to any output.

Decomposition:
- Package quad_enc_pkg holds:
  - FSM state enum {INIT, RUN}.
  - 2-bit Gray-state constants S00, S10, S11, S01.
  - A function next_fwd(state) returning the forward successor; reverse is the inverse lookup.
- Sub-module quad_channel_filter (2-flop synchroniser + debounce counter, parameter FILTER_CYCLES, bypass input for INIT). Instantiated once per channel.
- Decoder, FSM and error logic live in the top.

Test Plan (FILTER_CYCLES=3, clk period 10):
1. ch_a=1, ch_b=1 during reset; release rstn -> up, down and err stay 0 through INIT and afterwards; internal filt settles to 11.
2. From 00, step {a,b} 10->11->01->00, each held 10 cycles -> exactly 4 up pulses, each 1 cycle wide; the first rises at the 6th edge after ch_a changes; dir=1; down never asserts.
3. Reverse sequence 01->11->10->00 -> exactly 4 down pulses; dir=0 after the first one.
4. ch_a high for 2 cycles only, then 1 and 3 cycles -> no pulse for the 1- and 2-cycle glitches; the 3-cycle one yields one up pulse and a down pulse when it drops back.
5. Toggle a and b together 00->11 -> err=1, no pulse. Pulse err_clr -> err=0 next edge. Repeat the illegal transition coincident with err_clr -> err stays 1.
6. enable=0 across 2 forward steps -> no pulses, dir=1. enable=1 then one step -> exactly one up pulse. Assert rstn mid-pulse -> up drops immediately and INIT is re-entered.
